// File: rtl/m_vector_fetch_engine_pkg.sv
// rtl/m_vector_fetch_engine_pkg.sv - shared types and address helper for the vector fetch engine
// Traversal modes, FSM states and the quadrant-interleave index map.
package m_vector_pkg;

  typedef enum logic {
    LINEAR   = 1'b0,
    QUADRANT = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Element i of a layer lives at quadrant (i%4), offset i/4 within that quadrant.
  function automatic int unsigned quad_map(input int unsigned i, input int unsigned vec_len);
    return (i % 4) * (vec_len / 4) + i / 4;
  endfunction

endpackage

// File: rtl/m_vector_fetch_engine_if.sv
// rtl/m_vector_fetch_engine_if.sv - memory read port and element stream of the vector fetch engine
// master = engine side, slave = memory plus consumer side.
interface m_vector_fetch_engine_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int LAYER_W = 2
);
  logic [ADDR_W-1:0]  vector_memory_address;
  logic               memory_enable;
  logic               memory_write;
  logic [DATA_W-1:0]  vector_element;
  logic               m_element_requested;
  logic               m_element_ready;
  logic [DATA_W-1:0]  m_element;
  logic               m_element_last;
  logic [LAYER_W-1:0] layer;
  logic               done;

  modport master (
    output vector_memory_address, memory_enable, memory_write,
    output m_element_ready, m_element, m_element_last, layer, done,
    input  vector_element, m_element_requested
  );

  modport slave (
    input  vector_memory_address, memory_enable, memory_write,
    input  m_element_ready, m_element, m_element_last, layer, done,
    output vector_element, m_element_requested
  );
endinterface

// File: rtl/m_vector_fetch_engine_fifo.sv
// rtl/m_vector_fetch_engine_fifo.sv - synchronous prefetch FIFO with occupancy count
// Push and pop may coincide at any count; a push into a full FIFO is accepted only alongside a pop.
module m_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clock,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/m_vector_fetch_engine.sv
// rtl/m_vector_fetch_engine.sv - streams NUM_LAYERS x VEC_LEN vector elements to the MAC datapath
// Issues reads only while FIFO room covers all outstanding reads, so returns never overflow.
module m_vector_fetch_engine
  import m_vector_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int VEC_LEN    = 16,
  parameter int NUM_LAYERS = 4,
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                     i_clock,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic                     i_mode,
  m_vector_fetch_engine_if.master  bus
);
  localparam int IDX_W   = $clog2(VEC_LEN);
  localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int TAG_W   = LAYER_W + 1;
  localparam int FIFO_W  = DATA_W + TAG_W;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [LAYER_W-1:0] r_issue_layer;
  mode_t              r_mode;
  logic [CNT_W-1:0]   r_in_flight;
  logic [MEM_LAT-1:0] r_vld;
  logic [TAG_W-1:0]   r_tag [MEM_LAT];
  logic               r_done;

  mode_t              w_mode;
  logic [31:0]        w_map_full;
  logic [31:0]        w_addr_full;
  logic [CNT_W:0]     w_occupancy;
  logic               w_issue;
  logic               w_last_idx;
  logic               w_final_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_final_pop;
  logic [FIFO_W-1:0]  w_fifo_dout;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_head_last;
  logic [LAYER_W-1:0] w_head_layer;
  logic               w_ready;

  // Mode comes straight from the input at i=0 so the first address of a layer already honours it.
  assign w_mode = (r_idx == '0) ? mode_t'(i_mode) : r_mode;

  always_comb begin
    w_map_full = 32'(r_idx);
    if (w_mode == QUADRANT) begin
      w_map_full = quad_map(32'(r_idx), 32'(VEC_LEN));
    end
  end

  assign w_addr_full   = 32'(BASE_ADDR) + 32'(r_issue_layer) * 32'(VEC_LEN) + w_map_full;
  assign w_occupancy   = (CNT_W+1)'(w_fifo_count) + (CNT_W+1)'(r_in_flight);
  assign w_issue       = !i_clear && i_en && ((r_state == IDLE) || (r_state == FETCH))
                         && !w_fifo_full && (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign w_last_idx    = (r_idx == IDX_W'(VEC_LEN - 1));
  assign w_final_issue = w_issue && w_last_idx && (r_issue_layer == LAYER_W'(NUM_LAYERS - 1));

  assign w_push       = r_vld[MEM_LAT-1];
  assign w_head_last  = w_fifo_dout[FIFO_W-1];
  assign w_head_layer = w_fifo_dout[DATA_W +: LAYER_W];
  assign w_ready      = !w_fifo_empty && (r_state != DONE);
  assign w_pop        = w_ready && bus.m_element_requested;
  assign w_final_pop  = w_pop && w_head_last && (w_head_layer == LAYER_W'(NUM_LAYERS - 1));

  m_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_clear (i_clear),
    .i_push  (w_push),
    .i_data  ({r_tag[MEM_LAT-1], bus.vector_element}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (w_issue) r_state <= w_final_issue ? DRAIN : FETCH;
        FETCH:   if (w_final_issue) r_state <= DRAIN;
        DRAIN:   if (w_final_pop) begin
                   r_state <= DONE;
                   r_done  <= 1'b1;
                 end
        default: r_state <= DONE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_idx         <= '0;
      r_issue_layer <= '0;
      r_mode        <= LINEAR;
      r_in_flight   <= '0;
      r_vld         <= '0;
    end else begin
      if (w_issue) begin
        if (r_idx == '0) r_mode <= mode_t'(i_mode);
        r_idx <= r_idx + IDX_W'(1);
        if (w_last_idx) r_issue_layer <= r_issue_layer + LAYER_W'(1);
      end
      case ({w_issue, w_push})
        2'b10:   r_in_flight <= r_in_flight + CNT_W'(1);
        2'b01:   r_in_flight <= r_in_flight - CNT_W'(1);
        default: r_in_flight <= r_in_flight;
      endcase
      r_vld[0] <= w_issue;
      for (int k = 1; k < MEM_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  // Tags ride alongside the valid bits; they are only consumed where the valid bit is set.
  always_ff @(posedge i_clock) begin
    r_tag[0] <= {w_last_idx, r_issue_layer};
    for (int k = 1; k < MEM_LAT; k++) begin
      r_tag[k] <= r_tag[k-1];
    end
  end

  assign bus.vector_memory_address = w_issue ? w_addr_full[ADDR_W-1:0] : '0;
  assign bus.memory_enable         = w_issue;
  assign bus.memory_write          = 1'b0;
  assign bus.m_element_ready       = w_ready;
  assign bus.m_element             = w_ready ? w_fifo_dout[DATA_W-1:0] : '0;
  assign bus.m_element_last        = w_ready && w_head_last;
  assign bus.layer                 = w_ready ? w_head_layer : '0;
  assign bus.done                  = r_done;
endmodule

// File: tb/tb_m_vector_fetch_engine.sv
// tb/tb_m_vector_fetch_engine.sv - scoreboard bench for the vector fetch engine
// Instance a uses default parameters; instance b uses MEM_LAT=3 and BASE_ADDR=0x3F8.
module tb_m_vector_fetch_engine;
  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [1:0]  lyr;
  } exp_t;

  logic clk = 1'b0;
  logic clear, en_a, en_b, mode_a, mode_b;
  int   checks, errors;
  exp_t sb[$];
  logic [9:0] aq[$];

  always #5 clk = ~clk;

  m_vector_fetch_engine_if #(.DATA_W(16), .ADDR_W(10), .LAYER_W(2)) bus_a ();
  m_vector_fetch_engine_if #(.DATA_W(16), .ADDR_W(10), .LAYER_W(2)) bus_b ();

  m_vector_fetch_engine u_dut_a (
    .i_clock (clk), .i_clear (clear), .i_en (en_a), .i_mode (mode_a), .bus (bus_a)
  );

  m_vector_fetch_engine #(.MEM_LAT(3), .BASE_ADDR(32'h3F8)) u_dut_b (
    .i_clock (clk), .i_clear (clear), .i_en (en_b), .i_mode (mode_b), .bus (bus_b)
  );

  // Memory: word k holds k+0x100, returned MEM_LAT cycles after the strobe.
  logic [15:0] pipe_a;
  logic [15:0] pipe_b [3];
  always_ff @(posedge clk) begin
    pipe_a    <= 16'(bus_a.vector_memory_address) + 16'h100;
    pipe_b[0] <= 16'(bus_b.vector_memory_address) + 16'h100;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign bus_a.vector_element = pipe_a;
  assign bus_b.vector_element = pipe_b[2];

  function automatic int exp_addr(input int base, input int l, input int i, input bit md);
    int off = md ? (i % 4) * 4 + i / 4 : i;
    return (base + l * 16 + off) & 'h3FF;
  endfunction

  task automatic fill_q(input int base, input bit md);
    exp_t e;
    sb.delete();
    aq.delete();
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 16; i++) begin
        e.data = 16'(exp_addr(base, l, i, md) + 'h100);
        e.last = (i == 15);
        e.lyr  = 2'(l);
        sb.push_back(e);
        aq.push_back(10'(exp_addr(base, l, i, md)));
      end
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    clear = 1'b1; en_a = 1'b0; en_b = 1'b0; mode_a = 1'b0; mode_b = 1'b0;
    bus_a.m_element_requested = 1'b0;
    bus_b.m_element_requested = 1'b0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] oa, ob;
    do_reset;
    #1;
    oa = {bus_a.vector_memory_address, bus_a.memory_enable, bus_a.memory_write, bus_a.m_element_ready,
          bus_a.m_element, bus_a.m_element_last, bus_a.layer, bus_a.done};
    ob = {bus_b.vector_memory_address, bus_b.memory_enable, bus_b.memory_write, bus_b.m_element_ready,
          bus_b.m_element, bus_b.m_element_last, bus_b.layer, bus_b.done};
    checks++;
    if (oa !== 32'h0) begin errors++; $display("FAIL reset_a outputs got %h want 0", oa); end
    checks++;
    if (ob !== 32'h0) begin errors++; $display("FAIL reset_b outputs got %h want 0", ob); end
  endtask

  task automatic test_linear;
    int first_x = -1, last_x = -1, ready_cyc = -1;
    bit wr_seen = 1'b0;
    exp_t got, e;
    do_reset;
    fill_q(0, 1'b0);
    for (int cyc = 0; cyc < 300 && sb.size() > 0; cyc++) begin
      @(negedge clk);
      mode_a = 1'b0; en_a = 1'b1; bus_a.m_element_requested = 1'b1;
      #1;
      if (cyc == 0) begin
        checks++;
        if (bus_a.memory_enable !== 1'b1) begin
          errors++; $display("FAIL lin_first_strobe got %b want 1", bus_a.memory_enable);
        end
      end
      if (bus_a.memory_write !== 1'b0) wr_seen = 1'b1;
      if (ready_cyc < 0 && bus_a.m_element_ready) ready_cyc = cyc;
      if (bus_a.m_element_ready && bus_a.m_element_requested) begin
        got = {bus_a.m_element, bus_a.m_element_last, bus_a.layer};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL lin_elem got %h want %h", got, e); end
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        if (sb.size() == 0) begin
          checks++;
          if (bus_a.done !== 1'b0) begin errors++; $display("FAIL lin_done_early got %b want 0", bus_a.done); end
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL lin_timeout left %0d want 0", sb.size()); end
    checks++;
    if (ready_cyc != 2) begin errors++; $display("FAIL lin_ready_latency got %0d want 2", ready_cyc); end
    checks++;
    if (last_x - first_x != 63) begin errors++; $display("FAIL lin_rate span got %0d want 63", last_x - first_x); end
    checks++;
    if ({bus_a.done, bus_a.m_element_ready} !== 2'b10) begin
      errors++; $display("FAIL lin_done got done=%b ready=%b want 1 0", bus_a.done, bus_a.m_element_ready);
    end
    checks++;
    if (wr_seen) begin errors++; $display("FAIL lin_mem_write got 1 want 0"); end
  endtask

  task automatic test_quadrant;
    exp_t got, e;
    do_reset;
    fill_q(0, 1'b1);
    for (int cyc = 0; cyc < 300 && sb.size() > 0; cyc++) begin
      @(negedge clk);
      mode_a = 1'b1; en_a = 1'b1; bus_a.m_element_requested = 1'b1;
      #1;
      if (bus_a.m_element_ready) begin
        got = {bus_a.m_element, bus_a.m_element_last, bus_a.layer};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL quad_elem got %h want %h", got, e); end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL quad_timeout left %0d want 0", sb.size()); end
    checks++;
    if (bus_a.done !== 1'b1) begin errors++; $display("FAIL quad_done got %b want 1", bus_a.done); end
  endtask

  task automatic test_backpressure;
    int issued = 0, taken = 0, occ, maxocc = 0;
    bit held_valid = 1'b0;
    exp_t got, held, e;
    do_reset;
    fill_q(0, 1'b0);
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      mode_a = 1'b0; en_a = 1'b1; bus_a.m_element_requested = (cyc % 12 == 11);
      #1;
      got = {bus_a.m_element, bus_a.m_element_last, bus_a.layer};
      if (held_valid) begin
        checks++;
        if (got !== held) begin errors++; $display("FAIL bp_hold got %h want %h", got, held); end
      end
      if (bus_a.memory_enable) issued++;
      occ = issued - taken;
      if (occ > maxocc) maxocc = occ;
      checks++;
      if (occ > 4) begin errors++; $display("FAIL bp_occupancy got %0d want <=4", occ); end
      held_valid = 1'b0;
      if (bus_a.m_element_ready && bus_a.m_element_requested) begin
        e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL bp_elem got %h want %h", got, e); end
        taken++;
      end else if (bus_a.m_element_ready) begin
        held = got;
        held_valid = 1'b1;
      end
    end
    checks++;
    if (taken != 10) begin errors++; $display("FAIL bp_taken got %0d want 10", taken); end
    checks++;
    if (maxocc != 4) begin errors++; $display("FAIL bp_max_occupancy got %0d want 4", maxocc); end
    en_a = 1'b0;
    bus_a.m_element_requested = 1'b0;
  endtask

  task automatic test_clear_inflight;
    int nstrobe = 0;
    bit late = 1'b0;
    logic [31:0] ob;
    do_reset;
    @(negedge clk);
    en_b = 1'b1; mode_b = 1'b0; bus_b.m_element_requested = 1'b0;
    #1;
    if (bus_b.memory_enable) nstrobe++;
    @(negedge clk);
    #1;
    if (bus_b.memory_enable) nstrobe++;
    @(negedge clk);
    clear = 1'b1; en_b = 1'b0;
    checks++;
    if (nstrobe != 2) begin errors++; $display("FAIL clr_strobes got %0d want 2", nstrobe); end
    @(negedge clk);
    #1;
    ob = {bus_b.vector_memory_address, bus_b.memory_enable, bus_b.memory_write, bus_b.m_element_ready,
          bus_b.m_element, bus_b.m_element_last, bus_b.layer, bus_b.done};
    checks++;
    if (ob !== 32'h0) begin errors++; $display("FAIL clr_outputs got %h want 0", ob); end
    clear = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (bus_b.m_element_ready || bus_b.done) late = 1'b1;
    end
    checks++;
    if (late) begin errors++; $display("FAIL clr_late_data got 1 want 0"); end
  endtask

  // Continues from the cleared state left by test_clear_inflight: the restart must begin at element 0.
  task automatic test_en_gap_wrap;
    int nstrobe = 0, gap = 0;
    bit strobe_in_gap = 1'b0;
    logic [9:0] a;
    exp_t got, e;
    fill_q(32'h3F8, 1'b0);
    for (int cyc = 0; cyc < 400 && sb.size() > 0; cyc++) begin
      @(negedge clk);
      if (nstrobe == 6 && gap < 5) begin en_b = 1'b0; gap++; end
      else en_b = 1'b1;
      mode_b = 1'b0; bus_b.m_element_requested = 1'b1;
      #1;
      if (bus_b.memory_enable) begin
        if (!en_b) strobe_in_gap = 1'b1;
        checks++;
        if (aq.size() == 0) begin
          errors++; $display("FAIL gap_extra_strobe got addr %h want none", bus_b.vector_memory_address);
        end else begin
          a = aq.pop_front();
          if (bus_b.vector_memory_address !== a) begin
            errors++; $display("FAIL gap_addr got %h want %h", bus_b.vector_memory_address, a);
          end
        end
        nstrobe++;
      end
      if (bus_b.m_element_ready) begin
        got = {bus_b.m_element, bus_b.m_element_last, bus_b.layer};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL gap_elem got %h want %h", got, e); end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL gap_timeout left %0d want 0", sb.size()); end
    checks++;
    if (gap != 5) begin errors++; $display("FAIL gap_len got %0d want 5", gap); end
    checks++;
    if (strobe_in_gap) begin errors++; $display("FAIL gap_strobe_while_off got 1 want 0"); end
    checks++;
    if (aq.size() != 0) begin errors++; $display("FAIL gap_addr_left got %0d want 0", aq.size()); end
    checks++;
    if (bus_b.done !== 1'b1) begin errors++; $display("FAIL gap_done got %b want 1", bus_b.done); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear  = 1'b1;
    en_a   = 1'b0; en_b = 1'b0; mode_a = 1'b0; mode_b = 1'b0;
    bus_a.m_element_requested = 1'b0;
    bus_b.m_element_requested = 1'b0;
    test_reset;
    test_linear;
    test_quadrant;
    test_backpressure;
    test_clear_inflight;
    test_en_gap_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
